// File: rtl/clint_bus_arbiter.sv
// clint_bus_arbiter: registered round-robin arbiter sharing the CLINT stb/we/ack port between two masters.
// Define ARB_TIMEOUT_EN to abort a grant with an error ack after TIMEOUT cycles without slave ack.
module clint_bus_arbiter #(
   parameter int AW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [3:0]    i_m0_we,
   input  logic [31:0]   i_m0_dat_w,
   input  logic          i_m0_stb,
   output logic          o_m0_ack,
   output logic [31:0]   o_m0_dat_r,
   output logic          o_m0_err,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [3:0]    i_m1_we,
   input  logic [31:0]   i_m1_dat_w,
   input  logic          i_m1_stb,
   output logic          o_m1_ack,
   output logic [31:0]   o_m1_dat_r,
   output logic          o_m1_err,
   output logic [AW-1:0] o_s_addr,
   output logic [3:0]    o_s_we,
   output logic [31:0]   o_s_dat_w,
   output logic          o_s_stb,
   input  logic          i_s_ack,
   input  logic [31:0]   i_s_dat_r
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
   state_t state, state_nx;
   logic last_served, own0, own1, req, tmo, done;

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("clint_bus_arbiter: TIMEOUT must be 1..65535");
   end

   assign own0 = state == OWN0;
   assign own1 = state == OWN1;
   assign req  = (own0 & i_m0_stb) | (own1 & i_m1_stb);

`ifdef ARB_TIMEOUT_EN
   logic [15:0] cnt;
   // IDLE always precedes a grant, so clearing there restarts the count at every grant
   always_ff @(posedge i_clk)
      if (i_rst || state == IDLE) cnt <= '0;
      else cnt <= cnt + 16'd1;
   assign tmo = req & (cnt == 16'(TIMEOUT));
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      o_s_addr   = own0 ? i_m0_addr  : own1 ? i_m1_addr  : '0;
      o_s_we     = own0 ? i_m0_we    : own1 ? i_m1_we    : '0;
      o_s_dat_w  = own0 ? i_m0_dat_w : own1 ? i_m1_dat_w : '0;
      o_s_stb    = req & ~tmo;
      done       = ((o_s_stb & i_s_ack) | tmo) & ~i_rst;
      o_m0_ack   = own0 & done;
      o_m1_ack   = own1 & done;
      o_m0_err   = o_m0_ack & tmo;
      o_m1_err   = o_m1_ack & tmo;
      o_m0_dat_r = (o_m0_ack & ~tmo & (i_m0_we == 4'd0)) ? i_s_dat_r : '0;
      o_m1_dat_r = (o_m1_ack & ~tmo & (i_m1_we == 4'd0)) ? i_s_dat_r : '0;
      state_nx   = (state == IDLE) ?
                      ((i_m0_stb & i_m1_stb) ? (last_served ? OWN0 : OWN1) :
                       i_m0_stb ? OWN0 : i_m1_stb ? OWN1 : IDLE) :
                   (done | ~req) ? IDLE : state;
   end

   // last_served only moves on a completed (or timed-out) transfer, never on an abort
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state       <= IDLE;
         last_served <= 1'b1;
      end else begin
         state <= state_nx;
         if (done) last_served <= own1;
      end
endmodule
